// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller wrapped around a dual-port RAM with a registered read.
// An output register plus a one-entry skid buffer present the data as a first-word-fall-through stream.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_we1,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  output logic [DATA_WIDTH-1:0] ram_data1,
  output logic                  ram_we2,
  output logic [ADDR_WIDTH-1:0] ram_addr2,
  output logic [DATA_WIDTH-1:0] ram_data2,
  input  logic [DATA_WIDTH-1:0] ram_out2
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  rd_pend;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;

  logic       push;
  logic       pop;
  logic       issue;
  logic [1:0] occ;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign in_ready  = (ram_cnt != FULL_CNT);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Only read when the word will have somewhere to land: out slot or skid.
  assign occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
  assign issue     = (ram_cnt != '0) && (occ <= ({1'b0, pop} + 2'd1));

  assign ram_we1   = push;
  assign ram_addr1 = wptr;
  assign ram_data1 = in_data;
  assign ram_we2   = 1'b0;
  assign ram_addr2 = rptr;
  assign ram_data2 = '0;

  assign count = {1'b0, ram_cnt} + (ADDR_WIDTH+2)'(rd_pend)
               + (ADDR_WIDTH+2)'(out_valid) + (ADDR_WIDTH+2)'(skid_valid);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)
        wptr <= next_ptr(wptr);
      if (issue)
        rptr <= next_ptr(rptr);
      rd_pend <= issue;
      if (push && !issue)
        ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(1);
      else if (!push && issue)
        ram_cnt <= ram_cnt - (ADDR_WIDTH+1)'(1);
    end
  end

  // The skid word is always older than a word arriving from the RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (pop && skid_valid) begin
        out_data <= skid_data;
        if (rd_pend)
          skid_data <= ram_out2;
        else
          skid_valid <= 1'b0;
      end else if (!out_valid || pop) begin
        if (rd_pend) begin
          out_data  <= ram_out2;
          out_valid <= 1'b1;
        end else if (pop) begin
          out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_data  <= ram_out2;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule
